write_pointer_full: RTL and testbench
=====================================

Name: write_pointer_full

Overview:
Write-domain pointer and full-flag generator of the async FIFO. It sits directly downstream of the read-to-write pointer synchronizer and consumes its two-flop-synchronized Gray read pointer. It produces:
- the binary RAM write address
- the Gray write pointer sent to the write-to-read synchronizer
- registered full and almost-full flags
- a sticky overflow error

Parameters:
address_size, 3, RAM address width; FIFO depth = 2^address_size; pointers are address_size+1 bits
almost_full_margin, 2, write_almost_full asserts when free slots <= margin; legal range 1..depth-1

Ports:
write_clk  input  1  write-domain clock; all state updates on its rising edge
write_reset  input  1  asynchronous, active-high reset
write_increment  input  1  write request from the producer
write_to_read_pointer  input  address_size+1  synchronized Gray read pointer (from the r2w synchronizer)
write_overflow_clear  input  1  clears the sticky overflow flag
write_address  output  address_size  binary RAM write address
write_pointer  output  address_size+1  Gray write pointer to the w2r synchronizer
write_full  output  1  FIFO full, registered
write_almost_full  output  1  free slots <= almost_full_margin, registered
write_overflow  output  1  sticky: a write was attempted while full
write_free_count  output  address_size+1  free slots, registered (only with the optional feature)

Behaviour:
- Reset: while write_reset=1, all state clears immediately, independent of the clock.
  - binary pointer, write_pointer, write_address = 0
  - write_full, write_almost_full, write_overflow = 0
  - write_free_count = depth
- Accept = write_increment & ~write_full. Writes while full are dropped; the pointer does not move.
- Next-state computation:
  - bin_next = bin + accept, modulo 2^(address_size+1)
  - gray_next = (bin_next >> 1) ^ bin_next
  - All outputs are registered from the *_next values, so latency is one write_clk.
- write_address = bin[address_size-1:0], a direct slice of the registered binary pointer.
- write_full_next = (gray_next == {~rq[MSB], ~rq[MSB-1], rq[MSB-2:0]}), where rq = write_to_read_pointer.
  - write_full asserts on the same edge that accepts the depth-th write.
  - For address_size=1 the compare inverts both bits.
- Read-pointer conversion: rbin is obtained combinationally from rq by a prefix-XOR, rbin[i] = ^rq[MSB:i].
- used = bin_next - rbin, modulo 2^(address_size+1); range 0..depth.
- write_almost_full_next = (depth - used <= almost_full_margin). It is always 1 whenever write_full_next is 1.
- Flag pessimism: both flags deassert only after a read-side advance has passed the synchronizer and the next write_clk edge.
  - Never deasserting early is required.
  - Late deassertion is correct.
- Wrap-around: the pointer runs 2^(address_size+1)-1 -> 0 with no special handling. The MSB difference distinguishes full from empty.
- Overflow flag:
  - Sets on the edge where write_increment=1 and write_full=1.
  - Clears on the edge where write_overflow_clear=1.
  - If set and clear coincide, set wins.
- Reset asserted mid-write: the write is discarded and outputs go to reset values. After release, the first accepted write lands at address 0.
- write_to_read_pointer must be a valid Gray code (at most 1 bit change per cycle); no checking is required.

Optional Feature:
Macro WRITE_FREE_COUNT_EN.
- Defined:
  - The write_free_count port exists.
  - It is registered as depth - used, updated every write_clk edge, reset value depth.
  - It reads 0 exactly when write_full=1.
- Undefined:
  - The port and its register are absent.
  - All other behaviour is identical; write_almost_full still uses the internal used value.

Test Plan:
1. Reset mid-operation:
   - Stimulus: after 3 writes, assert write_reset between clock edges.
   - Response: write_pointer=0000, write_address=0, all flags 0 immediately. After release, the first write gives address 0, then write_pointer=0001.
2. Fill with read pointer held at 0000:
   - Stimulus: 8 consecutive write_increment.
   - Response: write_pointer follows 0001,0011,0010,0110,0111,0101,0100,1100.
   - write_almost_full=1 after the 6th write.
   - write_full=1 on the edge of the 8th write.
   - write_address goes 1..7 then 0.
3. Overflow:
   - Stimulus: while full, pulse write_increment.
   - Response: write_pointer stays 1100 and write_overflow=1 next edge.
   - Stimulus: then pulse write_overflow_clear.
   - Response: write_overflow=0.
   - Stimulus: simultaneous write-while-full and clear.
   - Response: write_overflow=1.
4. Read progress:
   - Stimulus: from full, drive write_to_read_pointer=0001.
   - Response: write_full=0 after the next edge.
   - Stimulus: one write.
   - Response: write_pointer=1101 and write_full=1 again.
5. Wrap:
   - Stimulus: 20 writes with write_to_read_pointer tracking gray(bin-2).
   - Response: write_pointer passes 1000 -> 0000 -> 0001 with no full assertion and write_almost_full=0 throughout.
6. WRITE_FREE_COUNT_EN defined:
   - Response: count reads 8 after reset, 5 after 3 writes (read pointer 0000), and 0 when full.
   - Response: with the macro undefined, the port is absent and the other outputs match the defined build cycle for cycle.

Source files
------------

// File: rtl/write_pointer_full.sv
// Write-side pointer and full/almost-full flag logic of an async FIFO.
// Define WRITE_FREE_COUNT_EN to add the registered write_free_count output.
module write_pointer_full #(
  parameter int address_size       = 3,
  parameter int almost_full_margin = 2
) (
  input  logic                    write_clk,
  input  logic                    write_reset,
  input  logic                    write_increment,
  input  logic [address_size:0]   write_to_read_pointer,
  input  logic                    write_overflow_clear,
  output logic [address_size-1:0] write_address,
  output logic [address_size:0]   write_pointer,
  output logic                    write_full,
  output logic                    write_almost_full,
`ifdef WRITE_FREE_COUNT_EN
  output logic [address_size:0]   write_free_count,
`endif
  output logic                    write_overflow
);

  localparam int PW = address_size + 1;
  localparam logic [PW-1:0] DEPTH     = PW'(1 << address_size);
  localparam logic [PW-1:0] MARGIN    = PW'(almost_full_margin);
  // Full means the read pointer is one lap behind: top two Gray bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_gray;
  logic          r_full;
  logic          r_almost_full;
  logic          r_overflow;

  logic          w_accept;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_gray_next;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_used;
  logic [PW-1:0] w_free;
  logic          w_full_next;
  logic          w_almost_full_next;
  logic          w_overflow_next;

  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign w_rbin[gi] = ^write_to_read_pointer[PW-1:gi];
    end
  endgenerate

  assign w_accept           = write_increment & ~r_full;
  assign w_bin_next         = r_bin + PW'(w_accept);
  assign w_gray_next        = (w_bin_next >> 1) ^ w_bin_next;
  assign w_full_next        = (w_gray_next == (write_to_read_pointer ^ FULL_MASK));
  assign w_used             = w_bin_next - w_rbin;
  assign w_free             = DEPTH - w_used;
  assign w_almost_full_next = (w_free <= MARGIN);

  always_comb begin
    w_overflow_next = r_overflow;
    if (write_increment && r_full) begin
      w_overflow_next = 1'b1;
    end else if (write_overflow_clear) begin
      w_overflow_next = 1'b0;
    end
  end

  always_ff @(posedge write_clk or posedge write_reset) begin
    if (write_reset) begin
      r_bin         <= '0;
      r_gray        <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_bin         <= w_bin_next;
      r_gray        <= w_gray_next;
      r_full        <= w_full_next;
      r_almost_full <= w_almost_full_next;
      r_overflow    <= w_overflow_next;
    end
  end

`ifdef WRITE_FREE_COUNT_EN
  logic [PW-1:0] r_free;

  always_ff @(posedge write_clk or posedge write_reset) begin
    if (write_reset) begin
      r_free <= DEPTH;
    end else begin
      r_free <= w_free;
    end
  end

  assign write_free_count = r_free;
`endif

  assign write_address     = r_bin[address_size-1:0];
  assign write_pointer     = r_gray;
  assign write_full        = r_full;
  assign write_almost_full = r_almost_full;
  assign write_overflow    = r_overflow;

endmodule

// File: tb/tb_write_pointer_full.sv
// Scoreboard bench for write_pointer_full: a counting model of writes and reads
// predicts each cycle's outputs; a monitor compares them after every write_clk edge.
module tb_write_pointer_full;

  localparam int AS     = 3;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic       write_clk = 1'b0;
  logic       write_reset = 1'b1;
  logic       write_increment = 1'b0;
  logic [3:0] write_to_read_pointer = '0;
  logic       write_overflow_clear = 1'b0;
  logic [2:0] write_address;
  logic [3:0] write_pointer;
  logic       write_full;
  logic       write_almost_full;
  logic       write_overflow;
`ifdef WRITE_FREE_COUNT_EN
  logic [3:0] write_free_count;
`endif

  write_pointer_full #(.address_size(AS), .almost_full_margin(MARGIN)) dut (
    .write_clk             (write_clk),
    .write_reset           (write_reset),
    .write_increment       (write_increment),
    .write_to_read_pointer (write_to_read_pointer),
    .write_overflow_clear  (write_overflow_clear),
    .write_address         (write_address),
    .write_pointer         (write_pointer),
    .write_full            (write_full),
    .write_almost_full     (write_almost_full),
`ifdef WRITE_FREE_COUNT_EN
    .write_free_count      (write_free_count),
`endif
    .write_overflow        (write_overflow)
  );

  always #5 write_clk = ~write_clk;

  typedef struct packed {
    logic [3:0] ptr;
    logic [2:0] addr;
    logic       full;
    logic       afull;
    logic       ovf;
    logic [3:0] free;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_txn  = 0;

  // Model state: total accepted writes and total reads the producer has seen.
  int   m_wr  = 0;
  int   m_rd  = 0;
  logic m_full = 1'b0;
  logic m_ovf  = 1'b0;

  function automatic logic [3:0] gray4(input int x);
    int y;
    y = ((x % 16) + 16) % 16;
    return 4'(y ^ (y >> 1));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One write_clk cycle: drive inputs at the falling edge, predict, enqueue.
  task automatic step(input logic inc, input logic clr);
    int   used;
    exp_t e;
    @(negedge write_clk);
    write_increment       = inc;
    write_overflow_clear  = clr;
    write_to_read_pointer = gray4(m_rd);
    if (inc && m_full) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
    if (inc && !m_full) m_wr++;
    used   = m_wr - m_rd;
    m_full = (used == DEPTH);
    e.ptr   = gray4(m_wr);
    e.addr  = 3'(m_wr % DEPTH);
    e.full  = m_full;
    e.afull = ((DEPTH - used) <= MARGIN);
    e.ovf   = m_ovf;
    e.free  = 4'(DEPTH - used);
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int rd_start);
    @(negedge write_clk);
    write_reset = 1'b1;
    write_increment = 1'b0;
    write_overflow_clear = 1'b0;
    m_wr = 0; m_rd = rd_start; m_full = 1'b0; m_ovf = 1'b0;
    write_to_read_pointer = gray4(m_rd);
    @(negedge write_clk);
    write_reset = 1'b0;
  endtask

  // Monitor: after each edge, compare the DUT against the oldest prediction.
  always @(posedge write_clk) begin
    exp_t e;
    #1;
    if (!write_reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_txn++;
      $display("txn %0d: ptr=%b addr=%0d full=%b afull=%b ovf=%b", n_txn,
               write_pointer, write_address, write_full, write_almost_full, write_overflow);
      chk("write_pointer", int'(write_pointer), int'(e.ptr));
      chk("write_address", int'(write_address), int'(e.addr));
      chk("write_full", int'(write_full), int'(e.full));
      chk("write_almost_full", int'(write_almost_full), int'(e.afull));
      chk("write_overflow", int'(write_overflow), int'(e.ovf));
`ifdef WRITE_FREE_COUNT_EN
      chk("write_free_count", int'(write_free_count), int'(e.free));
`endif
    end
  end

  initial begin
    // Reset values while held in reset
    #2;
    chk("reset_ptr", int'(write_pointer), 0);
    chk("reset_full", int'(write_full), 0);
`ifdef WRITE_FREE_COUNT_EN
    chk("reset_free", int'(write_free_count), DEPTH);
`endif
    do_reset(0);

    // Reset mid-operation: asynchronous clear between edges
    repeat (3) step(1'b1, 1'b0);
`ifdef WRITE_FREE_COUNT_EN
    @(posedge write_clk); #2;
    chk("free_after_3", int'(write_free_count), 5);
`else
    @(posedge write_clk); #2;
`endif
    write_increment = 1'b1;
    #1 write_reset = 1'b1;
    #1;
    chk("async_rst_ptr", int'(write_pointer), 0);
    chk("async_rst_addr", int'(write_address), 0);
    chk("async_rst_flags", int'({write_full, write_almost_full, write_overflow}), 0);
    do_reset(0);
    chk("first_write_addr", int'(write_address), 0);
    step(1'b1, 1'b0);

    // Fill with the read pointer held at 0
    do_reset(0);
    repeat (8) step(1'b1, 1'b0);
    @(posedge write_clk); #2;
    chk("fill_ptr", int'(write_pointer), 4'b1100);
    chk("fill_full", int'(write_full), 1);
`ifdef WRITE_FREE_COUNT_EN
    chk("fill_free", int'(write_free_count), 0);
`endif

    // Overflow: set, clear, then coincident set+clear
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    @(posedge write_clk); #2;
    chk("ovf_set_wins", int'(write_overflow), 1);
    chk("ovf_ptr_held", int'(write_pointer), 4'b1100);

    // Read progress then refill
    m_rd = 1;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    @(posedge write_clk); #2;
    chk("refill_ptr", int'(write_pointer), 4'b1101);

    // Wrap with the read pointer trailing by two
    do_reset(-2);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      m_rd++;
    end

    // Randomized traffic with alternating read-rate phases
    do_reset(0);
    for (int i = 0; i < 600; i++) begin
      int rd_pct;
      rd_pct = ((i / 100) % 2 == 0) ? 20 : 70;
      if (m_rd < m_wr && $urandom_range(99) < rd_pct) m_rd++;
      step(($urandom_range(99) < 75) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 10) ? 1'b1 : 1'b0);
    end

    repeat (3) @(posedge write_clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
